j11mem: RTL

Bus target for the DCJ11 front end. It consumes the single-request bus produced by `j11int` (`busreq`/`buswr`/`busgp`/`busaddr`/`buswdata`) and answers with `busack`/`busrdata`. Each request is routed to one of three places: a fixed-latency word RAM, the 8 KB I/O page handshake port, or an internal responder for GP cycles and nonexistent memory. A timeout keeps the CPU from hanging on an I/O access that nobody answers.

---
 rtl/j11pkg.sv | 37 +++
 rtl/j11timer.sv | 26 ++
 rtl/j11mem.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/j11pkg.sv
// j11pkg: shared constants, FSM states and decode classes for the j11mem bus target.
package j11pkg;

    localparam logic [8:0] IOPAGE  = 9'o777;
    localparam int         TIMER_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RAMWAIT,
        S_IOWAIT,
        S_ACK
    } state_t;

    typedef enum logic [1:0] {
        CLS_GP,
        CLS_IO,
        CLS_RAM,
        CLS_NXM
    } cls_t;

    // GP beats the I/O page, which beats RAM; whatever is left is nonexistent.
    function automatic cls_t decodeClass(input logic        gp,
                                         input logic [21:0] addr,
                                         input logic [21:0] ramTop);
        cls_t cls;
        if (gp)
            cls = CLS_GP;
        else if (addr[21:13] == IOPAGE)
            cls = CLS_IO;
        else if (addr < ramTop)
            cls = CLS_RAM;
        else
            cls = CLS_NXM;
        return cls;
    endfunction

endpackage

// File: rtl/j11timer.sv
// j11timer: loadable down-counter that parks at zero and flags it, shared by
// the RAM latency wait and the I/O timeout.
module j11timer
    import j11pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_value,
    output logic               o_zero
);

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_count <= '0;
        else if (i_load)
            r_count <= i_value;
        else if (r_count != '0)
            r_count <= r_count - TIMER_W'(1);
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/j11mem.sv
// j11mem: DCJ11 bus target routing each request to word RAM, the I/O page
// handshake port, or an internal responder for GP cycles and nonexistent memory.
module j11mem
    import j11pkg::*;
#(
    parameter int          RAMLAT  = 1,
    parameter logic [21:0] RAMTOP  = 22'o1000000,
    parameter int          TIMEOUT = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_busreq,
    input  logic        i_buswr,
    input  logic        i_busgp,
    input  logic [21:0] i_busaddr,
    input  logic [15:0] i_buswdata,
    output logic        o_busack,
    output logic [15:0] o_busrdata,
    output logic        o_memen,
    output logic        o_memwe,
    output logic [20:0] o_memaddr,
    output logic [15:0] o_memwdata,
    input  logic [15:0] i_memrdata,
    output logic        o_ioreq,
    output logic        o_iowr,
    output logic [11:0] o_ioaddr,
    output logic [15:0] o_iowdata,
    input  logic        i_ioack,
    input  logic [15:0] i_iordata,
    input  logic        i_nxmclr,
    output logic        o_nxm
);

    state_t             r_state;
    cls_t               r_cls;
    logic               r_wr;
    logic               r_busack;
    logic [15:0]        r_busrdata;
    logic               r_memen;
    logic               r_memwe;
    logic [20:0]        r_memaddr;
    logic [15:0]        r_memwdata;
    logic               r_ioreq;
    logic               r_iowr;
    logic [11:0]        r_ioaddr;
    logic [15:0]        r_iowdata;
    logic               r_nxm;

    cls_t               w_cls;
    logic               w_start;
    logic               w_timerZero;
    logic [TIMER_W-1:0] w_loadValue;

    assign w_cls       = decodeClass(i_busgp, i_busaddr, RAMTOP);
    assign w_start     = (r_state == S_IDLE) && i_busreq;
    // Loaded with TIMEOUT-1 so it reaches zero on the TIMEOUT-th cycle of ioreq.
    assign w_loadValue = (w_cls == CLS_IO) ? TIMER_W'(TIMEOUT - 1) : TIMER_W'(RAMLAT);

    j11timer u_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_start),
        .i_value (w_loadValue),
        .o_zero  (w_timerZero)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cls      <= CLS_GP;
            r_wr       <= 1'b0;
            r_busack   <= 1'b0;
            r_busrdata <= '0;
            r_memen    <= 1'b0;
            r_memwe    <= 1'b0;
            r_memaddr  <= '0;
            r_memwdata <= '0;
            r_ioreq    <= 1'b0;
            r_iowr     <= 1'b0;
            r_ioaddr   <= '0;
            r_iowdata  <= '0;
            r_nxm      <= 1'b0;
        end else begin
            r_memen  <= 1'b0;
            r_memwe  <= 1'b0;
            r_busack <= 1'b0;
            r_nxm    <= r_nxm & ~i_nxmclr;

            unique case (r_state)
                S_IDLE: begin
                    if (i_busreq) begin
                        r_cls <= w_cls;
                        r_wr  <= i_buswr;
                        unique case (w_cls)
                            CLS_RAM: begin
                                r_memen    <= 1'b1;
                                r_memwe    <= i_buswr;
                                r_memaddr  <= i_busaddr[21:1];
                                r_memwdata <= i_buswdata;
                                r_state    <= S_RAMWAIT;
                            end
                            CLS_IO: begin
                                r_ioreq   <= 1'b1;
                                r_iowr    <= i_buswr;
                                r_ioaddr  <= i_busaddr[12:1];
                                r_iowdata <= i_buswdata;
                                r_state   <= S_IOWAIT;
                            end
                            // GP and NXM pass through RAMWAIT for one cycle so
                            // their ack lines up with a RAM write.
                            default: r_state <= S_RAMWAIT;
                        endcase
                    end
                end

                S_RAMWAIT: begin
                    if (r_cls != CLS_RAM) begin
                        r_busrdata <= '0;
                        r_busack   <= 1'b1;
                        r_state    <= S_ACK;
                        if (r_cls == CLS_NXM)
                            r_nxm <= 1'b1;
                    end else if (r_wr) begin
                        r_busack <= 1'b1;
                        r_state  <= S_ACK;
                    end else if (w_timerZero) begin
                        r_busrdata <= i_memrdata;
                        r_busack   <= 1'b1;
                        r_state    <= S_ACK;
                    end
                end

                S_IOWAIT: begin
                    if (i_ioack) begin
                        if (!r_wr)
                            r_busrdata <= i_iordata;
                        r_ioreq  <= 1'b0;
                        r_busack <= 1'b1;
                        r_state  <= S_ACK;
                    end else if (w_timerZero) begin
                        r_ioreq    <= 1'b0;
                        r_busrdata <= 16'o177777;
                        r_nxm      <= 1'b1;
                        r_busack   <= 1'b1;
                        r_state    <= S_ACK;
                    end
                end

                S_ACK:   r_state <= S_IDLE;

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busack   = r_busack;
    assign o_busrdata = r_busrdata;
    assign o_memen    = r_memen;
    assign o_memwe    = r_memwe;
    assign o_memaddr  = r_memaddr;
    assign o_memwdata = r_memwdata;
    assign o_ioreq    = r_ioreq;
    assign o_iowr     = r_iowr;
    assign o_ioaddr   = r_ioaddr;
    assign o_iowdata  = r_iowdata;
    assign o_nxm      = r_nxm;

endmodule
